core_mem_bridge: RTL and testbench
==================================

# core_mem_bridge

Sequencer between the RISC-V core's load/store stage and the AXI4-Lite peripheral subsystem's start/busy command port. It takes one core memory request at a time and aligns store data and byte strobes to the 32-bit bus. It issues a single-cycle write or read start pulse, tracks the busy handshake with a timeout, and extracts and extends load data. It returns a one-cycle acknowledge to the core, which is stalled for the whole transaction.

## Interface
- ADDR_WIDTH, 32, address width (matches address-map package)
- DATA_WIDTH, 32, data width; only 32 supported
- TIMEOUT_CYCLES, 256, max wait cycles per transaction before error completion
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- core_req  in  1  request valid; held stable by core until core_ack
- core_we  in  1  1 = store, 0 = load
- core_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- core_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- core_addr  in  ADDR_WIDTH  byte address
- core_wdata  in  DATA_WIDTH  store data, right-aligned
- core_rdata  out  DATA_WIDTH  load result, valid with core_ack
- core_ack  out  1  one-cycle completion pulse
- core_err  out  1  error flag, valid with core_ack
- core_stall  out  1  core_req && !core_ack (combinational)
- write_start  out  1  one-cycle write command pulse
- write_addr  out  ADDR_WIDTH  word-aligned write address
- write_data  out  DATA_WIDTH  lane-replicated store data
- write_strobe  out  4  byte strobes
- write_busy  in  1  write in progress
- read_start  out  1  one-cycle read command pulse
- read_addr  out  ADDR_WIDTH  word-aligned read address
- read_data  in  DATA_WIDTH  read result, valid when read_busy falls
- read_busy  in  1  read in progress

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE: when core_req=1 and write_busy=0 and read_busy=0, latch we/size/unsigned/addr/wdata. If any subsystem busy is high, remain in IDLE; this covers a leftover transaction after a timeout.
- Alignment check at accept: size 11, half with addr[0]=1, or word with addr[1:0]≠00 -> RESP with err=1, no bus activity.
- ISSUE: drive write_start or read_start high for exactly this cycle. Address = addr with bits[1:0] cleared; timeout counter cleared. -> WAIT_HI.
- WAIT_HI: wait for the selected busy=1. -> WAIT_LO.
- WAIT_LO: wait for the selected busy=0. For loads, capture read_data in this cycle. -> RESP.
- Timeout: counter increments each WAIT_HI/WAIT_LO cycle. When it reaches TIMEOUT_CYCLES-1 with no completion -> RESP with err=1 and rdata=0.
- RESP: core_ack=1 for one cycle, with core_err and core_rdata. -> IDLE. A new request is not accepted in the RESP cycle.
- Store formatting, with o = addr[1:0]:
  - Byte: data = {4{wdata[7:0]}}, strobe = 4'b0001<<o.
  - Half: data = {2{wdata[15:0]}}, strobe = 4'b0011<<o.
  - Word: data = wdata, strobe = 4'b1111.
- Load extraction: lane = read_data >> (8*o). Byte and half results are sign- or zero-extended per core_unsigned; word is passed through.
- write_addr, write_data, write_strobe and read_addr hold their latched values from ISSUE until the next accept.

## Timing
- Reset: state IDLE. All outputs 0: core_rdata, core_ack, core_err, write_start, write_addr, write_data, write_strobe, read_start, read_addr. core_stall follows core_req.
- Reset asserted mid-transaction abandons the transaction; outputs are 0 on the following cycle and no ack is issued.
- Accept at cycle T, start pulse at T+1, WAIT_HI from T+2.
- If busy is high during T+2..T+k and low at T+k+1, data is captured at T+k+1 and ack occurs at T+k+2.
- Misaligned request accepted at T: ack+err at T+1.
- Exactly one start pulse per accepted aligned request; write_start and read_start are never high together.
- core_rdata is 0 for stores and error completions.

## Test plan
- Store byte: addr 0x1002, wdata 0xAB, busy high 3 cycles -> write_start once; write_addr 0x1000, write_data 0xABABABAB, strobe 0100; ack with err=0.
- Load half signed: addr 0x2002, read_data 0x80120000 -> core_rdata 0xFFFF8012. Same with core_unsigned=1 -> 0x00008012.
- Load word: read_busy high 1 cycle -> ack exactly 4 cycles after accept; core_rdata equals read_data.
- Misaligned word at 0x0001 -> ack+err next cycle, core_rdata 0; no start pulses.
- Timeout: read_busy held high, TIMEOUT_CYCLES=16 -> ack+err after 16 wait cycles. A next request is held in IDLE until read_busy drops, then issued.
- Reset low during WAIT_LO -> no ack; all outputs 0 next cycle; a fresh request after release completes normally.

Source files
------------

// File: rtl/core_mem_bridge.sv
// ---------------------------------------------------------------------------
// core_mem_bridge
//
// Sequences one load/store request from the core's memory stage onto the
// peripheral subsystem's start/busy command port. Store data is replicated
// across byte lanes with matching strobes, load data is shifted down from
// its lane and sign/zero-extended. The core sees a one-cycle acknowledge and
// is stalled for the whole transaction. A wait that exceeds TIMEOUT_CYCLES
// completes with an error so the core can never hang on a dead peripheral.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-low reset
//   core_req/we/size/unsigned/addr/wdata   request from the core
//   core_rdata/ack/err/stall                response to the core
//   write_start/addr/data/strobe, write_busy   write command port
//   read_start/addr, read_data, read_busy      read command port
// ---------------------------------------------------------------------------
module core_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [1:0]            core_size,
    input  logic                  core_unsigned,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_ack,
    output logic                  core_err,
    output logic                  core_stall,
    output logic                  write_start,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [3:0]            write_strobe,
    input  logic                  write_busy,
    output logic                  read_start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam int              CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            offset_q, offset_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] writeAddr_q, writeAddr_d;
    logic [DATA_WIDTH-1:0] writeData_q, writeData_d;
    logic [3:0]            writeStrobe_q, writeStrobe_d;
    logic [ADDR_WIDTH-1:0] readAddr_q, readAddr_d;

    logic                  misaligned;
    logic                  selBusy;
    logic [DATA_WIDTH-1:0] fmtData;
    logic [3:0]            fmtStrobe;
    logic [DATA_WIDTH-1:0] laneData;
    logic [DATA_WIDTH-1:0] loadResult;
    logic [ADDR_WIDTH-1:0] wordAddr;

    // Request decode: alignment check, word address and store lane
    // replication, all computed from the live request so they can be
    // latched in the accept cycle.
    always_comb begin
        misaligned = (core_size == 2'b11) ||
                     ((core_size == 2'b01) && core_addr[0]) ||
                     ((core_size == 2'b10) && (core_addr[1:0] != 2'b00));
        wordAddr   = {core_addr[ADDR_WIDTH-1:2], 2'b00};
        case (core_size)
            2'b00: begin
                fmtData   = {4{core_wdata[7:0]}};
                fmtStrobe = 4'b0001 << core_addr[1:0];
            end
            2'b01: begin
                fmtData   = {2{core_wdata[15:0]}};
                fmtStrobe = 4'b0011 << core_addr[1:0];
            end
            default: begin
                fmtData   = core_wdata;
                fmtStrobe = 4'b1111;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    // according to the latched size and signedness.
    always_comb begin
        laneData = read_data >> {offset_q, 3'b000};
        case (size_q)
            2'b00: loadResult = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, laneData[7:0]}
                                           : {{(DATA_WIDTH-8){laneData[7]}}, laneData[7:0]};
            2'b01: loadResult = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, laneData[15:0]}
                                           : {{(DATA_WIDTH-16){laneData[15]}}, laneData[15:0]};
            default: loadResult = laneData;
        endcase
    end

    assign selBusy = we_q ? write_busy : read_busy;

    // Transaction sequencer. A request is only accepted when neither busy
    // line is high, so a transaction abandoned by timeout drains before the
    // next one starts. The wait counter runs across both wait states; in
    // WAIT_LO completion is checked before the timeout so a transfer that
    // finishes on the last allowed cycle still succeeds.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        offset_d      = offset_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        writeAddr_d   = writeAddr_q;
        writeData_d   = writeData_q;
        writeStrobe_d = writeStrobe_q;
        readAddr_d    = readAddr_q;
        case (state_q)
            S_IDLE: begin
                if (core_req && !write_busy && !read_busy) begin
                    we_d       = core_we;
                    size_d     = core_size;
                    unsigned_d = core_unsigned;
                    offset_d   = core_addr[1:0];
                    rdata_d    = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                        if (core_we) begin
                            writeAddr_d   = wordAddr;
                            writeData_d   = fmtData;
                            writeStrobe_d = fmtStrobe;
                        end else begin
                            readAddr_d = wordAddr;
                        end
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (selBusy) begin
                        state_d = S_WAIT_LO;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!selBusy) begin
                    if (!we_q) begin
                        rdata_d = loadResult;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears every register so all
    // outputs read zero on the cycle after reset is sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            offset_q      <= 2'b00;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            writeAddr_q   <= '0;
            writeData_q   <= '0;
            writeStrobe_q <= 4'b0000;
            readAddr_q    <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            offset_q      <= offset_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
            writeAddr_q   <= writeAddr_d;
            writeData_q   <= writeData_d;
            writeStrobe_q <= writeStrobe_d;
            readAddr_q    <= readAddr_d;
        end
    end

    // Start pulses come straight from the ISSUE state, so exactly one fires
    // per issued transaction and never both at once. Response fields are
    // gated by the ack so they read zero outside the response cycle.
    assign write_start  = (state_q == S_ISSUE) && we_q;
    assign read_start   = (state_q == S_ISSUE) && !we_q;
    assign core_ack     = (state_q == S_RESP);
    assign core_err     = core_ack && err_q;
    assign core_rdata   = core_ack ? rdata_q : '0;
    assign core_stall   = core_req && !core_ack;
    assign write_addr   = writeAddr_q;
    assign write_data   = writeData_q;
    assign write_strobe = writeStrobe_q;
    assign read_addr    = readAddr_q;

endmodule

// File: tb/tb_core_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_core_mem_bridge
//
// Directed bench for core_mem_bridge. A driver issues core requests and
// pushes the expected bus command and expected core response into two
// queues; a monitor pops and compares whenever the bridge fires a start
// pulse or an acknowledge. A small responder plays the peripheral side.
// ---------------------------------------------------------------------------
module tb_core_mem_bridge;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_size;
    logic        core_unsigned;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ack;
    logic        core_err;
    logic        core_stall;
    logic        write_start;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_busy;
    logic        read_start;
    logic [31:0] read_addr;
    logic [31:0] read_data;
    logic        read_busy;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          reqCycle;
        int          lat;
    } expResp_t;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } expBus_t;

    expResp_t    respQ[$];
    expBus_t     busQ[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          busyLen = 1;
    logic [31:0] rdataVal = 32'h0;
    logic        hangMode = 1'b0;
    logic        releaseHang = 1'b0;

    core_mem_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_req(core_req),
        .core_we(core_we),
        .core_size(core_size),
        .core_unsigned(core_unsigned),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_ack(core_ack),
        .core_err(core_err),
        .core_stall(core_stall),
        .write_start(write_start),
        .write_addr(write_addr),
        .write_data(write_data),
        .write_strobe(write_strobe),
        .write_busy(write_busy),
        .read_start(read_start),
        .read_addr(read_addr),
        .read_data(read_data),
        .read_busy(read_busy)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure accept-to-ack latency.
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Give up loudly if something wedges the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Peripheral model: after a start pulse, raise the matching busy on the
    // next cycle and hold it for busyLen cycles (or until released in hang
    // mode), then drop it together with the read data.
    initial begin
        logic isW;
        logic isHang;
        write_busy = 1'b0;
        read_busy  = 1'b0;
        read_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (write_start || read_start) begin
                isW    = write_start;
                isHang = hangMode;
                @(posedge clk);
                #1;
                if (isW) write_busy = 1'b1;
                else     read_busy  = 1'b1;
                if (isHang) begin
                    while (!releaseHang) begin
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    repeat (busyLen) begin
                        @(posedge clk);
                        #1;
                    end
                end
                write_busy = 1'b0;
                read_busy  = 1'b0;
                read_data  = rdataVal;
            end
        end
    end

    // Monitor: every cycle check stall, start exclusivity, and pop/compare
    // the queued expectation for each start pulse and each acknowledge.
    initial begin
        expBus_t  b;
        expResp_t r;
        forever begin
            @(negedge clk);
            checkOutput("stall", {31'b0, core_stall}, {31'b0, core_req && !core_ack});
            checkOutput("startOverlap", {31'b0, write_start && read_start}, 32'h0);
            if (write_start || read_start) begin
                if (busQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedStart: got wr=%0b rd=%0b expected no pulse", write_start, read_start);
                end else begin
                    b = busQ.pop_front();
                    checkOutput("startDir", {31'b0, write_start}, {31'b0, b.isWrite});
                    if (b.isWrite) begin
                        checkOutput("writeAddr", write_addr, b.addr);
                        checkOutput("writeData", write_data, b.data);
                        checkOutput("writeStrobe", {28'b0, write_strobe}, {28'b0, b.strb});
                    end else begin
                        checkOutput("readAddr", read_addr, b.addr);
                    end
                end
            end
            if (core_ack) begin
                if (respQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedAck: got ack=1 expected ack=0");
                end else begin
                    r = respQ.pop_front();
                    checkOutput("rdata", core_rdata, r.rdata);
                    checkOutput("err", {31'b0, core_err}, {31'b0, r.err});
                    if (r.lat >= 0) begin
                        checkOutput("ackLatency", cycle - r.reqCycle, r.lat);
                    end
                end
            end
        end
    end

    task automatic startReq(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, output int reqCyc);
        @(posedge clk);
        #2;
        core_req      = 1'b1;
        core_we       = we;
        core_size     = size;
        core_unsigned = uns;
        core_addr     = addr;
        core_wdata    = wdata;
        reqCyc        = cycle;
    endtask

    task automatic waitAck();
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (core_ack) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        checkOutput("ackArrived", {31'b0, seen}, 32'h1);
        @(posedge clk);
        #2;
        core_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int bl, input logic [31:0] rdv,
                                 input logic [31:0] expRdata, input logic expErr, input int lat,
                                 input logic hasBus, input logic [31:0] busAddr,
                                 input logic [31:0] busData, input logic [3:0] busStrb);
        int       c;
        expBus_t  b;
        expResp_t r;
        busyLen  = bl;
        rdataVal = rdv;
        if (hasBus) begin
            b.isWrite = we;
            b.addr    = busAddr;
            b.data    = busData;
            b.strb    = busStrb;
            busQ.push_back(b);
        end
        startReq(we, size, uns, addr, wdata, c);
        r.rdata    = expRdata;
        r.err      = expErr;
        r.reqCycle = c;
        r.lat      = lat;
        respQ.push_back(r);
        waitAck();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".rdata"}, core_rdata, 32'h0);
        checkOutput({tag, ".ack"}, {31'b0, core_ack}, 32'h0);
        checkOutput({tag, ".err"}, {31'b0, core_err}, 32'h0);
        checkOutput({tag, ".wstart"}, {31'b0, write_start}, 32'h0);
        checkOutput({tag, ".waddr"}, write_addr, 32'h0);
        checkOutput({tag, ".wdata"}, write_data, 32'h0);
        checkOutput({tag, ".wstrb"}, {28'b0, write_strobe}, 32'h0);
        checkOutput({tag, ".rstart"}, {31'b0, read_start}, 32'h0);
        checkOutput({tag, ".raddr"}, read_addr, 32'h0);
    endtask

    // Main sequence: reset, directed vectors, timeout, mid-transfer reset.
    initial begin
        int       c;
        int       relCycle;
        int       n;
        logic     seen;
        expBus_t  b;
        expResp_t r;

        rst           = 1'b0;
        core_req      = 1'b1;
        core_we       = 1'b0;
        core_size     = 2'b00;
        core_unsigned = 1'b0;
        core_addr     = 32'h0;
        core_wdata    = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        checkOutput("resetStall", {31'b0, core_stall}, 32'h1);
        @(posedge clk);
        #2;
        core_req = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] directed vectors");
        //            we  size   uns  addr          wdata         bl rdv           expRdata      err lat bus busAddr       busData       strb
        applyStimulus(1, 2'b00, 0, 32'h0000_1002, 32'h1234_56AB, 3, 32'h0,        32'h0,        0,  6,  1,  32'h0000_1000, 32'hABAB_ABAB, 4'b0100);
        applyStimulus(0, 2'b01, 0, 32'h0000_2002, 32'h0,         2, 32'h8012_0000, 32'hFFFF_8012, 0,  5,  1,  32'h0000_2000, 32'h0,         4'b0000);
        applyStimulus(0, 2'b01, 1, 32'h0000_2002, 32'h0,         2, 32'h8012_0000, 32'h0000_8012, 0,  5,  1,  32'h0000_2000, 32'h0,         4'b0000);
        applyStimulus(0, 2'b10, 0, 32'h0000_2004, 32'h0,         1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0,  4,  1,  32'h0000_2004, 32'h0,         4'b0000);
        applyStimulus(0, 2'b10, 0, 32'h0000_0001, 32'h0,         1, 32'h1234_5678, 32'h0,        1,  1,  0,  32'h0,         32'h0,         4'b0000);
        applyStimulus(1, 2'b01, 0, 32'h0000_0006, 32'hFFFF_1234, 2, 32'h0,        32'h0,        0,  5,  1,  32'h0000_0004, 32'h1234_1234, 4'b1100);
        applyStimulus(1, 2'b10, 0, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h0,        32'h0,        0,  4,  1,  32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
        applyStimulus(0, 2'b00, 0, 32'h0000_0103, 32'h0,         1, 32'h9A00_0000, 32'hFFFF_FF9A, 0,  4,  1,  32'h0000_0100, 32'h0,         4'b0000);
        applyStimulus(0, 2'b00, 1, 32'h0000_0101, 32'h0,         2, 32'h0000_F500, 32'h0000_00F5, 0,  5,  1,  32'h0000_0100, 32'h0,         4'b0000);
        applyStimulus(0, 2'b00, 0, 32'h0000_0100, 32'h0,         1, 32'h0000_007F, 32'h0000_007F, 0,  4,  1,  32'h0000_0100, 32'h0,         4'b0000);
        applyStimulus(0, 2'b01, 0, 32'h0000_0000, 32'h0,         1, 32'h1234_7FFF, 32'h0000_7FFF, 0,  4,  1,  32'h0000_0000, 32'h0,         4'b0000);
        applyStimulus(0, 2'b01, 0, 32'h0000_0003, 32'h0,         1, 32'h0,        32'h0,        1,  1,  0,  32'h0,         32'h0,         4'b0000);
        applyStimulus(0, 2'b11, 0, 32'h0000_0000, 32'h0,         1, 32'h0,        32'h0,        1,  1,  0,  32'h0,         32'h0,         4'b0000);
        applyStimulus(1, 2'b10, 0, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0,        32'h0,        1,  1,  0,  32'h0,         32'h0,         4'b0000);

        $display("[TB] timeout and drain");
        hangMode    = 1'b1;
        releaseHang = 1'b0;
        b.isWrite = 1'b0; b.addr = 32'h0000_3000; b.data = 32'h0; b.strb = 4'b0000;
        busQ.push_back(b);
        startReq(0, 2'b10, 0, 32'h0000_3000, 32'h0, c);
        r.rdata = 32'h0; r.err = 1'b1; r.reqCycle = c; r.lat = 18;
        respQ.push_back(r);
        waitAck();
        // Second request must sit in IDLE while read_busy is still high.
        startReq(0, 2'b10, 1, 32'h0000_3004, 32'h0, c);
        repeat (6) @(negedge clk);
        checkOutput("heldStall", {31'b0, core_stall}, 32'h1);
        @(posedge clk);
        #2;
        b.isWrite = 1'b0; b.addr = 32'h0000_3004; b.data = 32'h0; b.strb = 4'b0000;
        busQ.push_back(b);
        busyLen  = 2;
        rdataVal = 32'h55AA_1234;
        relCycle = cycle;
        r.rdata = 32'h55AA_1234; r.err = 1'b0; r.reqCycle = relCycle + 1; r.lat = 5;
        respQ.push_back(r);
        hangMode    = 1'b0;
        releaseHang = 1'b1;
        waitAck();
        releaseHang = 1'b0;

        $display("[TB] reset during WAIT_LO");
        hangMode = 1'b1;
        b.isWrite = 1'b0; b.addr = 32'h0000_4008; b.data = 32'h0; b.strb = 4'b0000;
        busQ.push_back(b);
        startReq(0, 2'b10, 0, 32'h0000_4008, 32'h0, c);
        n    = 0;
        seen = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (read_start) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        checkOutput("readStartSeen", {31'b0, seen}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        core_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midReset");
        @(posedge clk);
        #2;
        hangMode    = 1'b0;
        releaseHang = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst         = 1'b1;
        releaseHang = 1'b0;
        applyStimulus(1, 2'b10, 0, 32'h0000_0020, 32'h1122_3344, 2, 32'h0, 32'h0, 0, 5, 1, 32'h0000_0020, 32'h1122_3344, 4'b1111);

        repeat (5) @(negedge clk);
        checkOutput("respQueueDrained", respQ.size(), 32'h0);
        checkOutput("busQueueDrained", busQ.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
